// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch sequencer: default widths,
//   HALT opcode and field bounds, FSM state encoding, saturating counter helper.
package fetch_pkg;

   localparam int FETCH_ADDR_W = 10;
   localparam int FETCH_DATA_W = 32;

   localparam int         OPC_HI   = 31;
   localparam int         OPC_LO   = 26;
   localparam logic [5:0] OPC_HALT = 6'h3F;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg
//   IF/ID output register. load captures a new word with its tag, flush
//   inserts a bubble (clears valid, keeps the previous word and pc), otherwise
//   holds. load has priority over flush.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   load, flush             register controls
//   d_instr, d_pc_plus_1    incoming word and its address + 1
//   d_valid                 incoming word is a real instruction
//   q_instr, q_pc_plus_1,
//   q_valid                 registered IF/ID contents
module fetch_out_reg #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] d_instr,
   input  logic [ADDR_W-1:0] d_pc_plus_1,
   input  logic              d_valid,
   output logic [DATA_W-1:0] q_instr,
   output logic [ADDR_W-1:0] q_pc_plus_1,
   output logic              q_valid
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q_instr     <= '0;
         q_pc_plus_1 <= '0;
         q_valid     <= 1'b0;
      end else if (load) begin
         q_instr     <= d_instr;
         q_pc_plus_1 <= d_pc_plus_1;
         q_valid     <= d_valid;
      end else if (flush) begin
         q_valid     <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch sequencer: owns the PC, drives the 1-cycle-latency
//   instruction memory address, applies jump redirects, stalls and HALT, and
//   presents a registered, tagged word to decode through fetch_out_reg.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   stall              hold PC and IF/ID contents
//   jump_valid,
//   jump_address       redirect request (wins over stall)
//   mem_addr           combinational instruction-memory read address
//   mem_data           memory read data, valid one cycle after its address
//   out_instr, out_pc_plus_1, out_valid   IF/ID contents
//   halted             HALT retired, fetch stopped until reset
//   stall_cycles       saturating count of stalled cycles
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | fetching; jump > stall > advance
// ST_HALTED | HALT loaded into IF/ID; pc frozen, jumps ignored, reset exits
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DATA_W   = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_address,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc_plus_1,
   output logic              out_valid,
   output logic              halted,
   output logic [15:0]       stall_cycles
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] rd_pc;
   logic              rd_valid;

   logic              run;
   logic              jump_take;
   logic              stall_take;
   logic              advance;
   logic              out_flush;
   logic              halt_seen;
   logic [ADDR_W-1:0] rd_pc_inc;

   assign run        = (state == ST_RUN);
   assign jump_take  = run && jump_valid;
   assign stall_take = stall && !jump_take;
   assign advance    = run && !jump_valid && !stall;
   // HALTED drains the IF/ID register to a bubble on its first unstalled cycle
   assign out_flush  = jump_take || (!run && !stall);
   assign halt_seen  = rd_valid && (mem_data[OPC_HI:OPC_LO] == OPC_HALT);
   assign rd_pc_inc  = rd_pc + 1'b1;

   // A stall re-issues the in-flight address so mem_data stays stable.
   always_comb begin
      mem_addr = pc;
      if (reset)
         mem_addr = RESET_PC;
      else if (jump_take)
         mem_addr = jump_address;
      else if (run && stall)
         mem_addr = rd_pc;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_RUN;
         pc           <= RESET_PC;
         rd_pc        <= RESET_PC;
         rd_valid     <= 1'b0;
         halted       <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (stall_take)
            stall_cycles <= sat_inc16(stall_cycles);
         case (state)
            ST_RUN: begin
               if (jump_valid) begin
                  pc       <= jump_address + 1'b1;
                  rd_pc    <= jump_address;
                  rd_valid <= 1'b1;
               end else if (!stall) begin
                  pc       <= pc + 1'b1;
                  rd_pc    <= pc;
                  rd_valid <= 1'b1;
                  if (halt_seen) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               rd_valid <= 1'b0;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   fetch_out_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clock       (clock),
      .reset       (reset),
      .load        (advance),
      .flush       (out_flush),
      .d_instr     (mem_data),
      .d_pc_plus_1 (rd_pc_inc),
      .d_valid     (rd_valid),
      .q_instr     (out_instr),
      .q_pc_plus_1 (out_pc_plus_1),
      .q_valid     (out_valid)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        jump_valid;
   logic [9:0]  jump_address;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;
   logic [31:0] out_instr;
   logic [9:0]  out_pc_plus_1;
   logic        out_valid;
   logic        halted;
   logic [15:0] stall_cycles;

   logic        halt_mode = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clock = ~clock;

   fetch_sequencer #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .jump_valid   (jump_valid),
      .jump_address (jump_address),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .out_instr    (out_instr),
      .out_pc_plus_1(out_pc_plus_1),
      .out_valid    (out_valid),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   // Instruction memory model: word k = 0x1000_0000 + k; HALT at 3 when enabled.
   always @(posedge clock) begin
      if (halt_mode && mem_addr == 10'd3)
         mem_data <= 32'hFC00_0000;
      else
         mem_data <= 32'h1000_0000 + {22'd0, mem_addr};
   end

   typedef struct {
      logic        stall;
      logic        jv;
      logic [9:0]  ja;
      logic [9:0]  exp_ma;
      logic        exp_valid;
      logic        chk_data;
      logic [31:0] exp_instr;
      logic [9:0]  exp_pc1;
      logic [15:0] exp_sc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic jv, input logic [9:0] ja,
                      input logic [9:0] ma, input logic v, input logic cd,
                      input logic [31:0] ins, input logic [9:0] p1,
                      input logic [15:0] sc);
      vec_t r;
      r.stall = st; r.jv = jv; r.ja = ja; r.exp_ma = ma; r.exp_valid = v;
      r.chk_data = cd; r.exp_instr = ins; r.exp_pc1 = p1; r.exp_sc = sc;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle, check mem_addr, then advance to just after the edge.
   task automatic cycle(input logic st, input logic jv, input logic [9:0] ja,
                        input logic chk_ma, input logic [9:0] exp_ma, input string name);
      stall = st; jump_valid = jv; jump_address = ja;
      #1;
      if (chk_ma) chk({name, " mem_addr"}, {22'd0, mem_addr}, {22'd0, exp_ma});
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; jump_valid = 1'b0; jump_address = '0;

      // cycle  stall jv ja      ma      v  chk instr           pc1     sc
      add(0, 0, 10'h000, 10'h000, 0, 0, 32'h0,           10'h000, 16'd0); // c0
      add(0, 0, 10'h000, 10'h001, 1, 1, 32'h1000_0000,   10'h001, 16'd0);
      add(0, 0, 10'h000, 10'h002, 1, 1, 32'h1000_0001,   10'h002, 16'd0);
      add(0, 0, 10'h000, 10'h003, 1, 1, 32'h1000_0002,   10'h003, 16'd0);
      add(0, 0, 10'h000, 10'h004, 1, 1, 32'h1000_0003,   10'h004, 16'd0);
      add(0, 0, 10'h000, 10'h005, 1, 1, 32'h1000_0004,   10'h005, 16'd0);
      add(1, 0, 10'h000, 10'h005, 1, 1, 32'h1000_0004,   10'h005, 16'd1); // stall x3
      add(1, 0, 10'h000, 10'h005, 1, 1, 32'h1000_0004,   10'h005, 16'd2);
      add(1, 0, 10'h000, 10'h005, 1, 1, 32'h1000_0004,   10'h005, 16'd3);
      add(0, 0, 10'h000, 10'h006, 1, 1, 32'h1000_0005,   10'h006, 16'd3);
      add(0, 0, 10'h000, 10'h007, 1, 1, 32'h1000_0006,   10'h007, 16'd3);
      add(0, 1, 10'h200, 10'h200, 0, 1, 32'h1000_0006,   10'h007, 16'd3); // jump
      add(0, 0, 10'h000, 10'h201, 1, 1, 32'h1000_0200,   10'h201, 16'd3);
      add(1, 1, 10'h300, 10'h300, 0, 1, 32'h1000_0200,   10'h201, 16'd3); // jump+stall
      add(0, 0, 10'h000, 10'h301, 1, 1, 32'h1000_0300,   10'h301, 16'd3);
      add(0, 1, 10'h3FE, 10'h3FE, 0, 1, 32'h1000_0300,   10'h301, 16'd3); // wrap
      add(0, 0, 10'h000, 10'h3FF, 1, 1, 32'h1000_03FE,   10'h3FF, 16'd3);
      add(0, 0, 10'h000, 10'h000, 1, 1, 32'h1000_03FF,   10'h000, 16'd3);
      add(0, 0, 10'h000, 10'h001, 1, 1, 32'h1000_0000,   10'h001, 16'd3);

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("reset mem_addr", {22'd0, mem_addr}, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_instr", out_instr, 32'd0);
      chk("reset out_pc_plus_1", {22'd0, out_pc_plus_1}, 32'd0);
      chk("reset halted", {31'd0, halted}, 32'd0);
      chk("reset stall_cycles", {16'd0, stall_cycles}, 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         cycle(vecs[i].stall, vecs[i].jv, vecs[i].ja, 1'b1, vecs[i].exp_ma, nm);
         chk({nm, " out_valid"}, {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].chk_data) begin
            chk({nm, " out_instr"}, out_instr, vecs[i].exp_instr);
            chk({nm, " out_pc_plus_1"}, {22'd0, out_pc_plus_1}, {22'd0, vecs[i].exp_pc1});
         end
         chk({nm, " stall_cycles"}, {16'd0, stall_cycles}, {16'd0, vecs[i].exp_sc});
         chk({nm, " halted"}, {31'd0, halted}, 32'd0);
      end

      // HALT at address 3, with reset issued mid-run from a non-zero state
      halt_mode = 1'b1;
      reset = 1'b1;
      cycle(0, 0, 10'h000, 1'b1, 10'h000, "halt reset");
      chk("halt reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("halt reset stall_cycles", {16'd0, stall_cycles}, 32'd0);
      reset = 1'b0;
      cycle(0, 0, 10'h000, 1'b1, 10'h000, "h0");
      cycle(0, 0, 10'h000, 1'b1, 10'h001, "h1");
      chk("h1 out_instr", out_instr, 32'h1000_0000);
      cycle(0, 0, 10'h000, 1'b1, 10'h002, "h2");
      cycle(0, 0, 10'h000, 1'b1, 10'h003, "h3");
      cycle(0, 0, 10'h000, 1'b1, 10'h004, "h4");
      chk("halt word out_instr", out_instr, 32'hFC00_0000);
      chk("halt word out_valid", {31'd0, out_valid}, 32'd1);
      chk("halt word out_pc_plus_1", {22'd0, out_pc_plus_1}, 32'd4);
      cycle(0, 0, 10'h000, 1'b1, 10'h005, "h5");
      chk("halted out_valid", {31'd0, out_valid}, 32'd0);
      chk("halted flag", {31'd0, halted}, 32'd1);
      cycle(0, 1, 10'h100, 1'b1, 10'h005, "halted jump");
      chk("halted jump out_valid", {31'd0, out_valid}, 32'd0);
      chk("halted jump halted", {31'd0, halted}, 32'd1);
      cycle(0, 0, 10'h000, 1'b1, 10'h005, "halted idle");
      chk("halted idle out_valid", {31'd0, out_valid}, 32'd0);

      // Reset exits HALTED and fetch restarts from RESET_PC
      halt_mode = 1'b0;
      reset = 1'b1;
      cycle(0, 0, 10'h000, 1'b1, 10'h000, "unhalt reset");
      chk("unhalt halted", {31'd0, halted}, 32'd0);
      chk("unhalt out_valid", {31'd0, out_valid}, 32'd0);
      reset = 1'b0;
      cycle(0, 0, 10'h000, 1'b1, 10'h000, "r0");
      chk("r0 out_valid", {31'd0, out_valid}, 32'd0);
      cycle(0, 0, 10'h000, 1'b1, 10'h001, "r1");
      chk("r1 out_valid", {31'd0, out_valid}, 32'd1);
      chk("r1 out_instr", out_instr, 32'h1000_0000);
      chk("r1 out_pc_plus_1", {22'd0, out_pc_plus_1}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
